// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The merge queue carries {addr, data} entries.
package regfile_wb_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready writeback offers from the ALU and memory sources.
interface regfile_wb_arbiter_if;
  import regfile_wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/wb_order_fifo.sv
// Ordered merge queue: up to two pushes (first, second) and one pop per cycle.
// Exposes the per-slot valid vector so the top can build the pending mask.
module wb_order_fifo
  import regfile_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push0,
  input  logic             push1,
  input  wb_entry_t        din0,
  input  wb_entry_t        din1,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic [DEPTH-1:0] entry_valid,
  output wb_entry_t        entries [DEPTH]
);

  wb_entry_t        entries_q [DEPTH];
  wb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push0) entries_d[wr_ptr_q] = din0;
      if (push1) entries_d[wr_ptr_q + PTR_W'(1)] = din1;
      wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] offset;
    assign offset          = PTR_W'(gi) - rd_ptr_q;
    assign entry_valid[gi] = (CNT_W'(offset) < count_q);
  end

  assign head    = entries_q[rd_ptr_q];
  assign count   = count_q;
  assign entries = entries_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and memory writebacks into one ordered stream feeding the single
// register-file write port, and reports which registers have writes in flight.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  regfile_wb_arbiter_if.slave  wb,
  output logic                 reg_write,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic [NUM_REGS-1:0]  pending_mask,
  output logic                 idle
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] entry_valid;
  wb_entry_t        entries [DEPTH];
  wb_entry_t        head;
  wb_entry_t        alu_entry, mem_entry, first_entry, second_entry;
  logic             ready, alu_push, mem_push, both, push0, push1, pop;
  wb_src_e          rr_q, rr_d;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  // Ready keeps one slot spare so a dual push can never overflow.
  assign ready        = rst_n && !flush && (count <= CNT_W'(DEPTH - 2));
  assign wb.alu_ready = ready;
  assign wb.mem_ready = ready;

  // Writes to r0 still handshake but are dropped here.
  assign alu_push = wb.alu_valid && ready && (wb.alu_addr != '0);
  assign mem_push = wb.mem_valid && ready && (wb.mem_addr != '0);

  always_comb begin
    alu_entry    = '{addr: wb.alu_addr, data: wb.alu_data};
    mem_entry    = '{addr: wb.mem_addr, data: wb.mem_data};
    both         = alu_push && mem_push;
    push0        = alu_push || mem_push;
    push1        = both;
    first_entry  = alu_entry;
    second_entry = mem_entry;
    if (both ? (rr_q == SRC_MEM) : mem_push) begin
      first_entry  = mem_entry;
      second_entry = alu_entry;
    end
    rr_d = rr_q;
    if (both) rr_d = (rr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end

  assign pop = (count != '0) && !flush;

  wb_order_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push0       (push0),
    .push1       (push1),
    .din0        (first_entry),
    .din1        (second_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop) begin
      reg_write_d  = 1'b1;
      write_reg_d  = head.addr;
      write_data_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= SRC_ALU;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      rr_q         <= rr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask |= reg_onehot(entries[i].addr);
    end
    if (reg_write_q) pending_mask |= reg_onehot(write_reg_q);
  end

  assign idle       = (count == '0) && !reg_write_q;
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised scoreboard bench: a queue-level model predicts accepted writes and
// their drain order; a monitor pops and compares on every register-file write.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [7:0]  pending_mask;
  logic        idle;

  regfile_wb_arbiter_if wb_if ();

  regfile_wb_arbiter #(.DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wb           (wb_if),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pending_mask (pending_mask),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  // Reference model: entries held in the queue, the output stage, rr bit.
  wb_entry_t   mq[$];
  wb_entry_t   sb[$];
  wb_entry_t   ost;
  bit          ost_v = 1'b0;
  bit          rr = 1'b0;
  wb_entry_t   mon_e;
  logic [15:0] rf_seen [8];
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] exp_mask();
    logic [7:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].addr] = 1'b1;
    if (ost_v) m[ost.addr] = 1'b1;
    return m;
  endfunction

  // Monitor: every write on the register-file port must match the next prediction.
  always @(negedge clk) begin
    if (reg_write === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got r%0d=%h required no write", write_reg, write_data);
      end else begin
        mon_e = sb.pop_front();
        if (write_reg === mon_e.addr && write_data === mon_e.data) begin
          passed++;
          $display("write r%0d <= %h", write_reg, write_data);
        end else begin
          $display("FAIL write_order: got r%0d=%h required r%0d=%h",
                   write_reg, write_data, mon_e.addr, mon_e.data);
        end
      end
      rf_seen[write_reg] = write_data;
    end
  end

  task automatic step(input bit av, input logic [2:0] aa, input logic [15:0] ad,
                      input bit mv, input logic [2:0] ma, input logic [15:0] md,
                      input bit fl);
    bit        rdy, ap, mp;
    wb_entry_t a, m;
    @(negedge clk);
    #1;
    chk("pending_mask", pending_mask, exp_mask());
    chk("idle", idle, (mq.size() == 0 && !ost_v));
    chk("reg_write", reg_write, ost_v);
    wb_if.alu_valid = av; wb_if.alu_addr = aa; wb_if.alu_data = ad;
    wb_if.mem_valid = mv; wb_if.mem_addr = ma; wb_if.mem_data = md;
    flush = fl;
    #1;
    rdy = (mq.size() <= D - 2) && !fl;
    chk("alu_ready", wb_if.alu_ready, rdy);
    chk("mem_ready", wb_if.mem_ready, rdy);
    if (fl) begin
      mq.delete();
      ost_v = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        ost   = mq.pop_front();
        ost_v = 1'b1;
        sb.push_back(ost);
      end else begin
        ost_v = 1'b0;
      end
      a  = '{addr: aa, data: ad};
      m  = '{addr: ma, data: md};
      ap = av && rdy && (aa != 3'd0);
      mp = mv && rdy && (ma != 3'd0);
      if (ap && mp) begin
        if (!rr) begin mq.push_back(a); mq.push_back(m); end
        else     begin mq.push_back(m); mq.push_back(a); end
        rr = !rr;
      end else if (ap) begin
        mq.push_back(a);
      end else if (mp) begin
        mq.push_back(m);
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0);
  endtask

  task automatic reset_now();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    wb_if.alu_valid = 1'b0;
    wb_if.mem_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_write_reg", write_reg, 3'd0);
    chk("rst_write_data", write_data, 16'h0);
    chk("rst_pending_mask", pending_mask, 8'h0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_alu_ready", wb_if.alu_ready, 1'b0);
    chk("rst_mem_ready", wb_if.mem_ready, 1'b0);
    mq.delete();
    ost_v = 1'b0;
    rr    = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", wb_if.alu_ready, 1'b1);
    chk("post_rst_idle", idle, 1'b1);
  endtask

  initial begin
    bit          av, mv, fl;
    logic [2:0]  aa, ma;
    logic [15:0] ad, md;

    wb_if.alu_valid = 1'b0; wb_if.alu_addr = '0; wb_if.alu_data = '0;
    wb_if.mem_valid = 1'b0; wb_if.mem_addr = '0; wb_if.mem_data = '0;
    for (int i = 0; i < 8; i++) rf_seen[i] = 16'h0;

    reset_now();

    // Single ALU write into an empty queue.
    step(1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0, 0);
    idle_steps(4);
    chk("r3_value", rf_seen[3], 16'hBEEF);

    // Two simultaneous pairs to r1: ALU/MEM then MEM/ALU.
    step(1, 3'd1, 16'h1111, 1, 3'd1, 16'h2222, 0);
    step(1, 3'd1, 16'h1111, 1, 3'd1, 16'h2222, 0);
    idle_steps(6);
    chk("r1_final", rf_seen[1], 16'h1111);

    // Fill with dual pushes until readies drop.
    for (int i = 0; i < 5; i++)
      step(1, 3'(1 + i % 7), 16'(16'hA000 + i), 1, 3'(7 - i % 7), 16'(16'hB000 + i), 0);
    idle_steps(6);

    // Memory write to r0 handshakes but never reaches the port.
    step(0, 3'd0, 16'h0, 1, 3'd0, 16'h5555, 0);
    idle_steps(3);

    // Flush with three entries queued plus a simultaneous push.
    step(1, 3'd2, 16'hC001, 1, 3'd4, 16'hC002, 0);
    step(1, 3'd5, 16'hC003, 1, 3'd6, 16'hC004, 0);
    step(1, 3'd7, 16'hDEAD, 1, 3'd2, 16'hDEAD, 1);
    idle_steps(3);

    // Reset mid-drain.
    step(1, 3'd2, 16'hE001, 1, 3'd3, 16'hE002, 0);
    step(1, 3'd4, 16'hE003, 1, 3'd5, 16'hE004, 0);
    reset_now();
    idle_steps(2);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_now();
      end else begin
        av = ($urandom_range(0, 3) != 0);
        mv = ($urandom_range(0, 3) != 0);
        aa = 3'($urandom_range(0, 7));
        ma = 3'($urandom_range(0, 7));
        ad = 16'($urandom);
        md = 16'($urandom);
        fl = ($urandom_range(0, 31) == 0);
        step(av, aa, ad, mv, ma, md, fl);
      end
    end
    idle_steps(6);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
